// File: rtl/shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shared_mem_arbiter
// Description : Single-ported word RAM shared by NUM_PORTS requesters through
//               valid/ready request channels with round-robin arbitration.
//               Byte-enable writes, fixed READ_LATENCY response pipeline and
//               error responses for out-of-range or misaligned addresses.
// Ports       : clk        - system clock, rising edge
//               reset      - asynchronous active-high reset
//               req_valid  - per-port request valid
//               req_ready  - per-port grant (one-hot or zero)
//               req_write  - per-port 1=write, 0=read
//               req_addr   - per-port byte address, packed ADDR_WIDTH slices
//               req_wdata  - per-port write data, packed DATA_WIDTH slices
//               req_be     - per-port byte enables, packed DATA_WIDTH/8 slices
//               rsp_valid  - one-cycle response strobe to originating port
//               rsp_rdata  - shared read data, valid with rsp_valid
//               rsp_error  - error flag, valid with rsp_valid
// Revision    : 1.0 - initial release
// ============================================================================
module shared_mem_arbiter #(
   parameter int NUM_PORTS    = 2,
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_BYTES    = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_PORTS-1:0]              req_valid,
   output logic [NUM_PORTS-1:0]              req_ready,
   input  logic [NUM_PORTS-1:0]              req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_be,
   output logic [NUM_PORTS-1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]             rsp_rdata,
   output logic                              rsp_error
);

   localparam int BYTES_W   = DATA_WIDTH / 8;
   localparam int OFF_W     = $clog2(BYTES_W);
   localparam int NUM_WORDS = NUM_BYTES / BYTES_W;
   localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int PID_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(NUM_BYTES);
   localparam logic [PID_W-1:0]    LAST_PORT  = PID_W'(NUM_PORTS - 1);

   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

   logic [PID_W-1:0]      ptr_q, ptr_d;
   logic [NUM_PORTS-1:0]  grant;
   logic [PID_W-1:0]      gnt_id;
   logic                  gnt_any;

   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [BYTES_W-1:0]    sel_be;
   logic                  sel_write;
   logic                  addr_err;
   logic [IDX_W-1:0]      word_idx;
   logic                  wr_en;

   logic [NUM_PORTS-1:0]  stg_vld_d;
   logic [DATA_WIDTH-1:0] stg_data_d;
   logic                  stg_err_d;

   logic [NUM_PORTS-1:0]  vld_q  [READ_LATENCY];
   logic [DATA_WIDTH-1:0] data_q [READ_LATENCY];
   logic                  err_q  [READ_LATENCY];

   // Round-robin scan starting at the pointer, wrapping at NUM_PORTS.
   always_comb begin
      logic [PID_W:0]   sum;
      logic [PID_W-1:0] idx;
      grant   = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         sum = {1'b0, ptr_q} + (PID_W+1)'(k);
         if (sum >= (PID_W+1)'(NUM_PORTS)) begin
            sum = sum - (PID_W+1)'(NUM_PORTS);
         end
         idx = sum[PID_W-1:0];
         if (!gnt_any && req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = idx;
         end
      end
      // No grants while reset is held, even though reset release is async.
      if (reset) begin
         gnt_any = 1'b0;
      end
      if (gnt_any) begin
         grant[gnt_id] = 1'b1;
      end
   end

   assign req_ready = grant;
   assign ptr_d     = !gnt_any ? ptr_q :
                      (gnt_id == LAST_PORT) ? '0 : gnt_id + 1'b1;

   // Select the granted port's request fields.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      sel_write = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grant[p]) begin
            sel_addr  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
            sel_be    = req_be[p*BYTES_W +: BYTES_W];
            sel_write = req_write[p];
         end
      end
   end

   assign addr_err = ({1'b0, sel_addr} >= ADDR_LIMIT) ||
                     (sel_addr[OFF_W-1:0] != '0);
   assign word_idx = sel_addr[OFF_W +: IDX_W];
   assign wr_en    = gnt_any && sel_write && !addr_err;

   // Stage-0 contents: read data is the pre-write RAM word; writes and
   // errored requests return zero data.
   always_comb begin
      stg_vld_d  = grant;
      stg_err_d  = gnt_any && addr_err;
      stg_data_d = '0;
      if (gnt_any && !sel_write && !addr_err) begin
         stg_data_d = mem[word_idx];
      end
   end

   // RAM array is intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int j = 0; j < BYTES_W; j++) begin
            if (sel_be[j]) begin
               mem[word_idx][8*j +: 8] <= sel_wdata[8*j +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
         for (int s = 0; s < READ_LATENCY; s++) begin
            vld_q[s]  <= '0;
            data_q[s] <= '0;
            err_q[s]  <= 1'b0;
         end
      end else begin
         ptr_q     <= ptr_d;
         vld_q[0]  <= stg_vld_d;
         data_q[0] <= stg_data_d;
         err_q[0]  <= stg_err_d;
         for (int s = 1; s < READ_LATENCY; s++) begin
            vld_q[s]  <= vld_q[s-1];
            data_q[s] <= data_q[s-1];
            err_q[s]  <= err_q[s-1];
         end
      end
   end

   // Idle stages carry zero data/error, so outputs need no further gating.
   assign rsp_valid = vld_q[READ_LATENCY-1];
   assign rsp_rdata = data_q[READ_LATENCY-1];
   assign rsp_error = err_q[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_shared_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_mem_arbiter
// Description : Scoreboard bench for shared_mem_arbiter. Two instances share
//               the request inputs: one with READ_LATENCY=1, one with 3.
//               A reference arbiter/memory model predicts grants and
//               responses; expected responses are queued on acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_mem_arbiter;

   localparam int NP = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [1:0]    req_ready3;
   logic [1:0]    req_write;
   logic [63:0]   req_addr;
   logic [63:0]   req_wdata;
   logic [7:0]    req_be;
   logic [1:0]    rsp_valid1, rsp_valid3;
   logic [31:0]   rsp_rdata1, rsp_rdata3;
   logic          rsp_error1, rsp_error3;

   typedef struct {
      int          due;
      int          port;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        q1[$];
   exp_t        q3[$];
   logic [31:0] mmem [256];
   int          mptr;
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   shared_mem_arbiter #(.NUM_PORTS(NP), .READ_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_be(req_be), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
      .rsp_error(rsp_error1)
   );

   shared_mem_arbiter #(.NUM_PORTS(NP), .READ_LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready3),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_be(req_be), .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3),
      .rsp_error(rsp_error3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model and scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t        e;
      logic [1:0]  eg;
      int          gi;
      int          sel;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  be;
      eg  = 2'b00;
      sel = -1;
      if (reset) begin
         q1.delete();
         q3.delete();
         mptr = 0;
         check_eq("rst_ready", {req_ready3, req_ready}, 64'd0);
         check_eq("rst_rsp1", {rsp_valid1, rsp_rdata1, rsp_error1}, 64'd0);
         check_eq("rst_rsp3", {rsp_valid3, rsp_rdata3, rsp_error3}, 64'd0);
      end else begin
         if (q1.size() != 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            check_eq("rsp_lat1", {rsp_valid1, rsp_rdata1, rsp_error1},
                     {2'(1 << e.port), e.data, e.err});
         end else begin
            check_eq("idle_lat1", {rsp_valid1, rsp_rdata1, rsp_error1}, 64'd0);
         end
         if (q3.size() != 0 && q3[0].due == cyc) begin
            e = q3.pop_front();
            check_eq("rsp_lat3", {rsp_valid3, rsp_rdata3, rsp_error3},
                     {2'(1 << e.port), e.data, e.err});
         end else begin
            check_eq("idle_lat3", {rsp_valid3, rsp_rdata3, rsp_error3}, 64'd0);
         end

         for (int k = 0; k < NP; k++) begin
            gi = (mptr + k) % NP;
            if (sel < 0 && req_valid[gi]) begin
               sel    = gi;
               eg[gi] = 1'b1;
            end
         end
         check_eq("grant", {req_ready3, req_ready}, {eg, eg});

         if (sel >= 0) begin
            a      = req_addr[sel*32 +: 32];
            wd     = req_wdata[sel*32 +: 32];
            be     = req_be[sel*4 +: 4];
            e.port = sel;
            e.err  = (a >= 32'd1024) || (a[1:0] != 2'b00);
            e.data = (!req_write[sel] && !e.err) ? mmem[a[9:2]] : 32'd0;
            e.due  = cyc + 1;
            q1.push_back(e);
            e.due  = cyc + 3;
            q3.push_back(e);
            if (req_write[sel] && !e.err) begin
               for (int j = 0; j < 4; j++) begin
                  if (be[j]) mmem[a[9:2]][8*j +: 8] = wd[8*j +: 8];
               end
            end
            mptr = (sel + 1) % NP;
         end
      end
   end

   // Entered and left at posedge+1; holds the request until accepted.
   task automatic issue(input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      bit acc;
      acc = 1'b0;
      req_write[p]        = w;
      req_addr[p*32 +: 32]  = a;
      req_wdata[p*32 +: 32] = d;
      req_be[p*4 +: 4]      = be;
      req_valid[p]        = 1'b1;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         if (req_ready[p]) acc = 1'b1;
      end
      if (!acc) check_eq("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      req_valid[p] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      idle(2);

      // Basic write then read on the other port.
      issue(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      issue(0, 1'b0, 32'h10, 32'h0, 4'h0);

      // Partial write.
      issue(1, 1'b1, 32'h20, 32'h11223344, 4'hF);
      issue(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
      issue(0, 1'b0, 32'h20, 32'h0, 4'h0);

      // Back-to-back reads on port 0.
      issue(0, 1'b1, 32'h0, 32'hA0A0A0A0, 4'hF);
      issue(0, 1'b1, 32'h4, 32'hB1B1B1B1, 4'hF);
      issue(0, 1'b1, 32'h8, 32'hC2C2C2C2, 4'hF);
      issue(0, 1'b0, 32'h0, 32'h0, 4'h0);
      issue(0, 1'b0, 32'h4, 32'h0, 4'h0);
      issue(0, 1'b0, 32'h8, 32'h0, 4'h0);
      issue(1, 1'b0, 32'h20, 32'h0, 4'h0);

      // Contention: both ports valid for six cycles.
      req_write = 2'b00;
      req_addr  = {32'h20, 32'h10};
      req_valid = 2'b11;
      repeat (6) @(posedge clk);
      #1;
      req_valid = 2'b00;
      idle(4);

      // Error cases and no-op write.
      issue(0, 1'b0, 32'h400, 32'h0, 4'h0);
      issue(1, 1'b1, 32'h13, 32'h12345678, 4'hF);
      issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
      issue(0, 1'b0, 32'h2, 32'h0, 4'h0);
      issue(1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
      issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
      issue(1, 1'b1, 32'h3FC, 32'h55667788, 4'hF);
      issue(0, 1'b0, 32'h3FC, 32'h0, 4'h0);
      idle(4);

      // Reset with reads in flight, pointer left at port 1.
      issue(0, 1'b0, 32'h0, 32'h0, 4'h0);
      issue(0, 1'b0, 32'h4, 32'h0, 4'h0);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(3);
      req_write = 2'b00;
      req_addr  = {32'h8, 32'h4};
      req_valid = 2'b11;
      repeat (2) @(posedge clk);
      #1;
      req_valid = 2'b00;
      idle(6);

      check_eq("drain_lat1", 64'(q1.size()), 64'd0);
      check_eq("drain_lat3", 64'(q3.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Parametrised successor to the fixed two-port memory and CPU pairing.
- A single-ported word RAM is shared by NUM_PORTS requesters (instruction fetch, data, DMA, ...) through valid/ready request channels, with round-robin arbitration.
- Supports byte-enable writes, a configurable pipelined read latency, and error responses for out-of-range or misaligned accesses.
- Sits between the CPU/peripheral masters and memory at system top level.

Parameters:
NUM_PORTS, 2, number of requester ports (1..8)
ADDR_WIDTH, 32, byte-address width per port
DATA_WIDTH, 32, word width; must be 32 or 64
NUM_BYTES, 1024, RAM size in bytes; multiple of DATA_WIDTH/8
READ_LATENCY, 1, cycles from request acceptance to response (1..4)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_PORTS  per-port request valid
req_ready  output  NUM_PORTS  per-port grant; request accepted when valid&ready at clk edge
req_write  input  NUM_PORTS  1=write, 0=read
req_addr  input  NUM_PORTS*ADDR_WIDTH  byte addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  NUM_PORTS*DATA_WIDTH  write data, packed the same way
req_be  input  NUM_PORTS*DATA_WIDTH/8  byte enables, bit j writes byte lane j
rsp_valid  output  NUM_PORTS  one-cycle response strobe to the originating port
rsp_rdata  output  DATA_WIDTH  shared read data, valid with the asserted rsp_valid bit
rsp_error  output  1  error flag, valid with rsp_valid

Behaviour:
- Reset (async assert, sync release): arbitration pointer=0; response pipeline cleared; rsp_valid=0, rsp_rdata=0, rsp_error=0. RAM contents are not reset. In-flight responses are dropped. req_ready=0 while reset is high.
- Arbitration: combinational, at most one grant per cycle. Grant goes to the first port with req_valid=1 scanning from the pointer upward with wrap. On acceptance the pointer becomes (granted+1) mod NUM_PORTS; with no acceptance the pointer holds. req_ready is one-hot or zero.
- Masters hold valid, addr, write, wdata and be stable until accepted; the block does not register unaccepted requests.
- Address check: error if addr >= NUM_BYTES or addr[log2(DATA_WIDTH/8)-1:0] != 0. An errored request performs no RAM access; its response has rsp_error=1 and rsp_rdata=0.
- Write: byte lanes with be=1 are updated at the accepting edge, little-endian (lane 0 = lowest address). be=0 is a legal no-op write.
- Every accepted request, read or write, produces exactly one response, exactly READ_LATENCY cycles after acceptance. Write responses carry rsp_rdata=0 and rsp_error per the address check.
- Reads return RAM contents as of the accepting edge, before any write in the same cycle. Only one access occurs per cycle, so a read accepted the cycle after a write returns the new data.
- Pipeline: READ_LATENCY stages, each holding {valid, port id, data, error}. Accepts one request per cycle with no bubbles. Responses leave in acceptance order. There is no response backpressure; masters must always sink rsp_valid.
- Cycles with no accepted request: rsp_valid=0 at the corresponding output cycle; rsp_rdata and rsp_error are 0 when rsp_valid=0.
- NUM_PORTS=1: arbiter degenerates to req_ready=req_valid (outside reset).

Test Plan:
- Reset then idle: all outputs 0. With NUM_BYTES=1024, port1 writes 0xDEADBEEF to 0x10 with be=0xF, then port0 reads 0x10 -> port1 rsp_valid 1 cycle after acceptance with error=0; port0 rsp_rdata=0xDEADBEEF at READ_LATENCY.
- Partial write: word at 0x20 holds 0x11223344; write 0xAABBCCDD with be=0b0101 -> readback 0x11BB33DD.
- Contention: both ports hold valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; each port gets 3 responses in order, with no gap cycles.
- Errors: read 0x400 -> rsp_error=1, rdata=0. Write 0x13 -> rsp_error=1 and the RAM is unchanged at 0x10.
- READ_LATENCY=3: back-to-back reads of 0x0, 0x4, 0x8 on port0 -> three consecutive rsp_valid cycles starting 3 cycles after the first acceptance, with data in order.
- Assert reset while two reads are in flight -> no rsp_valid after reset deassertion; the pointer restarts at port 0.
